// File: rtl/multicycle_decoder.sv
// Moore control FSM for a multicycle ARM-style datapath, plus the
// combinational ALU, flag-write and immediate/register-source decoders.
module multicycle_decoder (
  input  logic        CLK,
  input  logic        RESETn,
  input  logic [31:0] Instr,
  input  logic        MemReady,
  output logic        MemReq,
  output logic        IRWrite,
  output logic        NextPC,
  output logic        AdrSrc,
  output logic        ALUSrcA,
  output logic        PCS,
  output logic        RegW,
  output logic        MemW,
  output logic        NoWrite,
  output logic [1:0]  ResultSrc,
  output logic [1:0]  ALUSrcB,
  output logic [1:0]  ALUControl,
  output logic [1:0]  ImmSrc,
  output logic [1:0]  RegSrc,
  output logic [1:0]  FlagW,
  output logic [3:0]  Cond,
  output logic [3:0]  State
);

  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    MEMADR = 4'd2,
    MEMRD  = 4'd3,
    MEMWB  = 4'd4,
    MEMWR  = 4'd5,
    EXECR  = 4'd6,
    EXECI  = 4'd7,
    ALUWB  = 4'd8,
    BRANCH = 4'd9
  } state_e;

  state_e     state_q, state_d;
  logic [1:0] op;
  logic [5:0] funct;
  logic [3:0] cmd;
  logic       rdIsPc, isCmpCmn, isArith;
  logic [1:0] aluDecoded;
  logic       memReqRaw, irWriteRaw, pcsRaw, regWRaw, memWRaw;
  logic [1:0] flagWRaw;

  assign op       = Instr[27:26];
  assign funct    = Instr[25:20];
  assign cmd      = funct[4:1];
  assign rdIsPc   = (Instr[15:12] == 4'hF);
  assign isCmpCmn = (cmd == 4'b1010) || (cmd == 4'b1011);
  assign isArith  = isCmpCmn || (cmd == 4'b0100) || (cmd == 4'b0010);

  assign NoWrite = (op == 2'b00) && isCmpCmn;
  assign ImmSrc  = op;
  assign RegSrc  = {op == 2'b01, op == 2'b10};
  assign Cond    = Instr[31:28];
  assign State   = state_q;

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) state_q <= FETCH;
    else         state_q <= state_d;
  end

  // Unused encodings 10-15 fall through to the default and recover to FETCH.
  always_comb begin
    state_d = FETCH;
    case (state_q)
      FETCH:  state_d = MemReady ? DECODE : FETCH;
      DECODE: begin
        case (op)
          2'b00:   state_d = funct[5] ? EXECI : EXECR;
          2'b01:   state_d = MEMADR;
          2'b10:   state_d = BRANCH;
          default: state_d = FETCH;
        endcase
      end
      MEMADR: state_d = funct[0] ? MEMRD : MEMWR;
      MEMRD:  state_d = MemReady ? MEMWB : MEMRD;
      MEMWR:  state_d = MemReady ? FETCH : MEMWR;
      EXECR,
      EXECI:  state_d = ALUWB;
      default: state_d = FETCH;
    endcase
  end

  always_comb begin
    aluDecoded = 2'b00;
    case (cmd)
      4'b0010, 4'b1010: aluDecoded = 2'b01;
      4'b0000:          aluDecoded = 2'b10;
      4'b1100:          aluDecoded = 2'b11;
      default:          aluDecoded = 2'b00;
    endcase
  end

  always_comb begin
    memReqRaw  = 1'b0;
    irWriteRaw = 1'b0;
    pcsRaw     = 1'b0;
    regWRaw    = 1'b0;
    memWRaw    = 1'b0;
    flagWRaw   = 2'b00;
    AdrSrc     = 1'b0;
    ALUSrcA    = 1'b0;
    ALUSrcB    = 2'b00;
    ResultSrc  = 2'b00;
    ALUControl = 2'b00;
    case (state_q)
      FETCH: begin
        memReqRaw  = 1'b1;
        irWriteRaw = MemReady;
        ALUSrcA    = 1'b1;
        ALUSrcB    = 2'b10;
        ResultSrc  = 2'b10;
      end
      DECODE: begin
        ALUSrcA   = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
      end
      MEMADR: ALUSrcB = 2'b01;
      MEMRD: begin
        memReqRaw = 1'b1;
        AdrSrc    = 1'b1;
      end
      MEMWB: begin
        ResultSrc = 2'b01;
        regWRaw   = 1'b1;
        pcsRaw    = rdIsPc;
      end
      MEMWR: begin
        memReqRaw = 1'b1;
        AdrSrc    = 1'b1;
        memWRaw   = 1'b1;
      end
      EXECR, EXECI: begin
        ALUSrcB    = (state_q == EXECI) ? 2'b01 : 2'b00;
        ALUControl = aluDecoded;
        flagWRaw   = {funct[0], funct[0] & isArith};
      end
      ALUWB: begin
        regWRaw = ~NoWrite;
        pcsRaw  = rdIsPc;
      end
      BRANCH: begin
        ALUSrcB   = 2'b01;
        ResultSrc = 2'b10;
        pcsRaw    = 1'b1;
      end
      default: ;
    endcase
  end

  // Strobes that change architectural state are held low while reset is asserted.
  assign MemReq  = RESETn & memReqRaw;
  assign IRWrite = RESETn & irWriteRaw;
  assign NextPC  = RESETn & irWriteRaw;
  assign PCS     = RESETn & pcsRaw;
  assign RegW    = RESETn & regWRaw;
  assign MemW    = RESETn & memWRaw;
  assign FlagW   = {2{RESETn}} & flagWRaw;

endmodule

// File: doc/multicycle_decoder.md
MULTICYCLE_DECODER -- requirements
Module: multicycle_decoder

Interface
REQ-001 SHALL have port: CLK  input  1  sole clock; all state updates on rising edge.
REQ-002 SHALL have port: RESETn  input  1  reset, asynchronous, active-low.
REQ-003 SHALL have port: Instr  input  32  current IR contents: Cond=[31:28], Op=[27:26], Funct=[25:20], Rd=[15:12].
REQ-004 SHALL have port: MemReady  input  1  memory handshake; 1 = access in progress completes this cycle.
REQ-005 SHALL have outputs, each 1 bit: MemReq, IRWrite, NextPC, AdrSrc, ALUSrcA, PCS, RegW, MemW, NoWrite.
REQ-006 SHALL have 2-bit outputs: ResultSrc, ALUSrcB, ALUControl, ImmSrc, RegSrc, FlagW.
REQ-007 SHALL have outputs: Cond (4 bits, Instr[31:28] passthrough) and State (4 bits, debug state code).

Function
REQ-010 SHALL implement Moore FSM codes: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXECR=6, EXECI=7, ALUWB=8, BRANCH=9; codes 10-15 SHALL go to FETCH next cycle.
REQ-011 FETCH: MemReq=1, AdrSrc=0, ALUSrcA=1, ALUSrcB=10, ResultSrc=10; IRWrite=NextPC=MemReady; stays in FETCH while MemReady=0, else goes to DECODE.
REQ-012 DECODE: ALUSrcA=1, ALUSrcB=10, ResultSrc=10. Next state: Op=00 & Funct[5]=0 -> EXECR; Op=00 & Funct[5]=1 -> EXECI; Op=01 -> MEMADR; Op=10 -> BRANCH; Op=11 -> FETCH, no writes.
REQ-013 MEMADR: ALUSrcA=0, ALUSrcB=01, ALU add. Next state: Funct[0]=1 -> MEMRD, else MEMWR.
REQ-014 MEMRD: MemReq=1, AdrSrc=1, ResultSrc=00; holds while MemReady=0, then goes to MEMWB.
REQ-015 MEMWB: ResultSrc=01, RegW=1; next FETCH.
REQ-016 MEMWR: MemReq=1, AdrSrc=1, MemW=1; MemW stays high every cycle until MemReady=1, then next FETCH.
REQ-017 EXECR: ALUSrcA=0, ALUSrcB=00, ALU decode active. EXECI: same but ALUSrcB=01. Both go to ALUWB.
REQ-018 ALUWB: ResultSrc=00, RegW=1 unless NoWrite; next FETCH.
REQ-019 BRANCH: ALUSrcA=0, ALUSrcB=01, ResultSrc=10, ALU add, PCS=1; next FETCH.
REQ-020 PCS SHALL also be 1 in MEMWB/ALUWB when Rd=1111.
REQ-021 ALU decode (EXECR/EXECI only), cmd=Funct[4:1]:
- ALUControl: ADD 0100 -> 00; SUB 0010 -> 01; AND 0000 -> 10; ORR 1100 -> 11; CMP 1010 -> 01; CMN 1011 -> 00; others -> 00.
- In all other states, ALUControl=00.
REQ-022 Flag writes:
- FlagW[1] = Funct[0] in EXECR/EXECI.
- FlagW[0] = Funct[0] & cmd in {ADD, SUB, CMP, CMN} in EXECR/EXECI.
- FlagW = 00 in all other states.
REQ-023 NoWrite SHALL be 1 when Op=00 and cmd is CMP or CMN, in any state.
REQ-024 ImmSrc SHALL equal Op; RegSrc[0]=(Op=10), RegSrc[1]=(Op=01); combinational, state-independent.
REQ-025 Exactly one state register update per CLK edge. Outputs SHALL be glitch-free functions of state plus Instr/MemReady as specified above; no other inputs.
REQ-026 MemReady SHALL be ignored in states other than FETCH, MEMRD and MEMWR.

Reset
REQ-030 RESETn=0 SHALL force state to FETCH immediately, including mid-instruction and mid-handshake.
REQ-031 While RESETn=0, the following SHALL be 0: MemReq, IRWrite, NextPC, PCS, RegW, MemW, FlagW.
REQ-032 First active edge after RESETn rises SHALL evaluate FETCH normally.

Verification
REQ-040 SHALL check: ADD R1,R2,R3 (Op=00, Funct=001000), MemReady=1 -> FETCH, DECODE, EXECR, ALUWB, FETCH (4 cycles); RegW=1 only in ALUWB; ALUControl=00 in EXECR.
REQ-041 SHALL check: CMP imm (Funct=110101) -> EXECI: FlagW=11, ALUControl=01, NoWrite=1; ALUWB: RegW=0.
REQ-042 SHALL check: LDR (Op=01, Funct[0]=1), MemReady low for 3 cycles in MEMRD -> remains MEMRD with MemReq=1 for 3 cycles, then MEMWB with RegW=1 and ResultSrc=01.
REQ-043 SHALL check: STR with MemReady=0 in FETCH for 2 cycles -> IRWrite=0 both cycles, IRWrite=1 on third; MEMWR: MemW=1 until MemReady=1.
REQ-044 SHALL check: B (Op=10) -> BRANCH with PCS=1; Op=11 -> DECODE returns to FETCH with no writes.
REQ-045 SHALL check: RESETn pulsed low during MEMWR -> State=0 and MemW=0 asynchronously; normal fetch resumes after release.
